// File: rtl/saturated_accum.sv
// Saturating signed accumulator with one result register and valid/ready on both sides.
// Every accepted sample's sum is clamped to [lim_lo, lim_hi] and reported with an ov flag.
module saturated_accum #(
  parameter int N = 8,
  parameter int M = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic         op,
  input  logic [M-1:0] lim_hi,
  input  logic [M-1:0] lim_lo,
  output logic [M-1:0] acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ov,
  output logic         ov_sticky,
  input  logic         ov_clr
);

  typedef struct packed {
    logic [N-1:0] x;
    logic         op;
    logic [M-1:0] hi;
    logic [M-1:0] lo;
  } req_t;

  req_t               req;
  logic               accept;
  logic signed [M:0]  acc_ext, x_ext, raw, hi_ext, lo_ext;
  logic        [M-1:0] res;
  logic               ov_nxt;

  assign req      = '{x: x, op: op, hi: lim_hi, lo: lim_lo};
  assign in_ready = !out_valid || out_ready;
  // Reset and clear both drop whatever is offered in that cycle.
  assign accept   = in_valid && in_ready && !clr && !rst;

  // One guard bit keeps the sum from wrapping before the clamp compares it.
  assign acc_ext = {acc[M-1], acc};
  assign x_ext   = {{(M+1-N){req.x[N-1]}}, req.x};
  assign hi_ext  = {req.hi[M-1], req.hi};
  assign lo_ext  = {req.lo[M-1], req.lo};
  assign raw     = req.op ? (acc_ext + x_ext) : (acc_ext - x_ext);

  // Upper limit is tested first so an inverted window still resolves deterministically.
  always_comb begin
    res    = raw[M-1:0];
    ov_nxt = 1'b0;
    if (raw > hi_ext) begin
      res    = req.hi;
      ov_nxt = 1'b1;
    end else if (raw < lo_ext) begin
      res    = req.lo;
      ov_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      acc       <= res;
      ov        <= ov_nxt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  ov_sticky <= 1'b0;
    else if (accept && ov_nxt) ov_sticky <= 1'b1;
    else if (ov_clr)          ov_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_saturated_accum.sv
// Directed bench for saturated_accum at N=8, M=10 with hand-computed expectations.
module tb_saturated_accum;
  localparam int N = 8;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, in_ready, op, out_valid, out_ready, ov, ov_sticky, ov_clr;
  logic [N-1:0] x;
  logic [M-1:0] lim_hi, lim_lo, acc;

  int checks = 0;
  int errors = 0;

  saturated_accum #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .op(op), .lim_hi(lim_hi), .lim_lo(lim_lo), .acc(acc),
    .out_valid(out_valid), .out_ready(out_ready), .ov(ov), .ov_sticky(ov_sticky),
    .ov_clr(ov_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int e_acc, input int e_vld,
                           input int e_ov, input int e_sticky);
    chk({tag, ".acc"}, $signed(acc), e_acc);
    chk({tag, ".out_valid"}, int'(out_valid), e_vld);
    chk({tag, ".ov"}, int'(ov), e_ov);
    chk({tag, ".ov_sticky"}, int'(ov_sticky), e_sticky);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; x = 8'd50; op = 1'b1;
    out_ready = 1'b1; ov_clr = 1'b0;
    lim_hi = 10'(511); lim_lo = 10'(-512);
    #1;
    chk("rst.in_ready", int'(in_ready), 1);
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset.in_ready", int'(in_ready), 1);

    // basic accumulation, one accept per cycle
    in_valid = 1'b1; x = 8'd100; op = 1'b1;
    step(); chk_state("acc1", 100, 1, 0, 0);
    step(); chk_state("acc2", 200, 1, 0, 0);
    step(); chk_state("acc3", 300, 1, 0, 0);
    in_valid = 1'b0;
    step(); chk_state("consumed", 300, 0, 0, 0);

    // upper saturation: reach 500, then overflow past 511
    clr = 1'b1; step(); clr = 1'b0;
    chk_state("clr", 0, 0, 0, 0);
    in_valid = 1'b1; x = 8'd127;
    step(); step(); step();
    x = 8'd119; step();
    chk_state("to500", 500, 1, 0, 0);
    x = 8'd127; step();
    chk_state("sat_hi", 511, 1, 1, 1);
    x = 8'(-128); step();
    chk_state("after_sat", 383, 1, 0, 1);
    in_valid = 1'b0; ov_clr = 1'b1; step(); ov_clr = 1'b0;
    chk_state("ov_clr", 383, 0, 0, 0);

    // lower saturation with programmable lim_lo
    clr = 1'b1; step(); clr = 1'b0;
    lim_lo = 10'(-100);
    in_valid = 1'b1; op = 1'b0; x = 8'd50; step();
    chk_state("sub50", -50, 1, 0, 0);
    x = 8'd127; step();
    chk_state("sat_lo", -100, 1, 1, 1);

    // inverted window: lim_lo > lim_hi, upper test wins
    lim_hi = 10'(10); lim_lo = 10'(20);
    op = 1'b1; x = 8'd127; step();
    chk_state("inv_hi", 10, 1, 1, 1);
    x = 8'd0; step();
    chk_state("inv_lo", 20, 1, 1, 1);

    // clear is not clamped even when 0 lies outside the window
    in_valid = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    chk_state("clr_noclamp", 0, 0, 0, 1);
    lim_hi = 10'(511); lim_lo = 10'(-512);
    ov_clr = 1'b1; step(); ov_clr = 1'b0;
    chk("sticky_cleared", int'(ov_sticky), 0);

    // back-pressure holds result and stalls the offered sample
    in_valid = 1'b1; x = 8'd1; op = 1'b1; step();
    chk_state("bp_first", 1, 1, 0, 0);
    out_ready = 1'b0; x = 8'd2; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", int'(in_ready), 0);
      step();
      chk_state("bp_hold", 1, 1, 0, 0);
    end
    out_ready = 1'b1; #1;
    chk("bp.release_ready", int'(in_ready), 1);
    step();
    chk_state("bp_accept", 3, 1, 0, 0);

    // clr beats a valid sample; sample is dropped
    clr = 1'b1; x = 8'd5; step(); clr = 1'b0;
    chk_state("clr_prio", 0, 0, 0, 0);
    in_valid = 1'b0; step();
    chk_state("clr_dropped", 0, 0, 0, 0);

    // ov event together with ov_clr: set wins
    lim_hi = 10'(5); in_valid = 1'b1; x = 8'd10; ov_clr = 1'b1; step();
    ov_clr = 1'b0; lim_hi = 10'(511);
    chk_state("set_wins", 5, 1, 1, 1);

    // reset mid-burst loses the in-flight result
    x = 8'd7; step();
    chk_state("burst", 12, 1, 0, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_state("mid_rst", 0, 0, 0, 0);
    x = 8'd5; step();
    chk_state("post_rst", 5, 1, 0, 0);
    in_valid = 1'b0; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
